regfile_bist: RTL and testbench

- Built-in self-test initiator for the 32x32 three-port register file: 2 combinational read ports (a1/rd1, a2/rd2) and 1 write port (a3/wd3/we3) written on the rising clock edge.
- Drives the write port with an address-dependent pattern, then reads every register back through both read ports and compares.
- Repeats with the inverted pattern, then reports pass or fail.
- Sits beside the register file behind a mux that the controller selects while busy=1.

---
 rtl/regfile_bist_pkg.sv | 28 ++
 rtl/regfile_bist_if.sv | 16 +
 rtl/regfile_bist_cmp.sv | 73 +++++++
 rtl/regfile_bist.sv | 155 +++++++++++++++
 tb/tb_regfile_bist.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bist_pkg.sv
// rtl/regfile_bist_pkg.sv - shared state type, default seed and expected-data function for regfile_bist
package regfile_bist_pkg;

  localparam int BIST_DATA_W = 32;
  localparam int BIST_ADDR_W = 5;
  localparam logic [BIST_DATA_W-1:0] SEED_DEFAULT = 32'hA5A5_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    FINISH = 2'd3
  } bist_state_t;

  // Register 0 is hardwired to zero, so it must read back zero in both phases.
  function automatic logic [BIST_DATA_W-1:0] exp_data(
    input logic [BIST_ADDR_W-1:0] addr,
    input logic                   phase,
    input logic [BIST_DATA_W-1:0] seed
  );
    logic [BIST_DATA_W-1:0] d;
    d = seed ^ {{(BIST_DATA_W-BIST_ADDR_W){1'b0}}, addr};
    if (phase) d = ~d;
    if (addr == '0) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// rtl/regfile_bist_if.sv - three-port register file bus (two combinational reads, one clocked write)
interface regfile_bist_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (output we3, a1, a2, a3, wd3, input rd1, rd2);
  modport slave  (input we3, a1, a2, a3, wd3, output rd1, rd2);
endinterface

// File: rtl/regfile_bist_cmp.sv
// rtl/regfile_bist_cmp.sv - registered two-port readback compare with first-fail capture
// REGFILE_BIST_ERRCNT_EN adds a saturating mismatch counter.
module regfile_bist_cmp
  import regfile_bist_pkg::*;
#(
  parameter int                DATA_W = BIST_DATA_W,
  parameter int                ADDR_W = BIST_ADDR_W,
  parameter logic [DATA_W-1:0] SEED   = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              phase,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic              mism,
  output logic              fail_flag,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port
`ifdef REGFILE_BIST_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  logic bad1;
  logic bad2;

  always_comb begin
    bad1 = en && (rd1 != exp_data(a1, phase, SEED));
    bad2 = en && (rd2 != exp_data(a2, phase, SEED));
    mism = bad1 || bad2;
  end

  // Only the first failing cycle is captured; rd1 wins a same-cycle tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_flag <= 1'b0;
      fail_addr <= '0;
      fail_port <= 1'b0;
    end else if (clear) begin
      fail_flag <= 1'b0;
      fail_addr <= '0;
      fail_port <= 1'b0;
    end else if (mism && !fail_flag) begin
      fail_flag <= 1'b1;
      fail_addr <= bad1 ? a1 : a2;
      fail_port <= !bad1;
    end
  end

`ifdef REGFILE_BIST_ERRCNT_EN
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_count} + {8'd0, bad1} + {8'd0, bad2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (err_sum > 9'd255) begin
      err_count <= 8'hFF;
    end else begin
      err_count <= err_sum[7:0];
    end
  end
`endif

endmodule

// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - march-style BIST initiator for the 32x32 three-port register file
// Optional macro REGFILE_BIST_ERRCNT_EN exposes err_count.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int                DATA_W   = BIST_DATA_W,
  parameter int                ADDR_W   = BIST_ADDR_W,
  parameter int                NUM_REGS = 2**BIST_ADDR_W,
  parameter logic [DATA_W-1:0] SEED     = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
`ifdef REGFILE_BIST_ERRCNT_EN
  output logic [7:0]        err_count,
`endif
  regfile_bist_if.master    rf
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  bist_state_t       state;
  bist_state_t       state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              phase;
  logic              phase_nxt;
  logic              launch;
  logic              mism;
  logic              fail_flag;

  assign launch = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      phase <= phase_nxt;
    end
  end

  // Writes skip register 0; reads cover all registers, a2 walking top-down.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
          idx_nxt   = ADDR_W'(1);
          phase_nxt = 1'b0;
        end
      end
      WRITE: begin
        if (idx == LAST) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      READ: begin
        if (idx == LAST) begin
          if (!phase) begin
            state_nxt = WRITE;
            idx_nxt   = ADDR_W'(1);
            phase_nxt = 1'b1;
          end else begin
            state_nxt = FINISH;
            idx_nxt   = '0;
          end
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        phase_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rf.we3 = 1'b0;
    rf.a1  = '0;
    rf.a2  = '0;
    rf.a3  = '0;
    rf.wd3 = '0;
    case (state)
      WRITE: begin
        busy   = 1'b1;
        rf.we3 = 1'b1;
        rf.a3  = idx;
        rf.wd3 = exp_data(idx, phase, SEED);
      end
      READ: begin
        busy  = 1'b1;
        rf.a1 = idx;
        rf.a2 = LAST - idx;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // The last compare lands on the same edge that enters FINISH, so fold it in here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (launch) begin
      pass <= 1'b0;
    end else if (state == READ && idx == LAST && phase) begin
      pass <= !(fail_flag || mism);
    end
  end

  regfile_bist_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SEED   (SEED)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (launch),
    .en        (state == READ),
    .phase     (phase),
    .a1        (idx),
    .a2        (LAST - idx),
    .rd1       (rf.rd1),
    .rd2       (rf.rd2),
    .mism      (mism),
    .fail_flag (fail_flag),
    .fail_addr (fail_addr),
    .fail_port (fail_port)
`ifdef REGFILE_BIST_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - randomized self-checking bench for regfile_bist with a fault-injecting regfile
`timescale 1ns/1ps
module tb_regfile_bist;

  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_addr;
  logic       fail_port;
`ifdef REGFILE_BIST_ERRCNT_EN
  logic [7:0] err_count;
`endif

  regfile_bist_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  regfile_bist #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_REGS (32),
    .SEED     (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_port (fail_port),
`ifdef REGFILE_BIST_ERRCNT_EN
    .err_count (err_count),
`endif
    .rf        (rf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Fault kinds: 0 good, 1 one bit of f_reg stuck at f_val, 2 register 0 reads all ones.
  int   f_kind = 0;
  int   f_reg = 9;
  int   f_bit = 3;
  logic f_val = 1'b0;
  logic [31:0] mem [32];

  function automatic logic [31:0] apply_fault(input int r, input logic [31:0] v);
    logic [31:0] o;
    if (r == 0) return (f_kind == 2) ? 32'hFFFF_FFFF : 32'h0;
    o = v;
    if (f_kind == 1 && r == f_reg) o[f_bit] = f_val;
    return o;
  endfunction

  always_comb begin
    rf.rd1 = apply_fault(int'(rf.a1), mem[rf.a1]);
    rf.rd2 = apply_fault(int'(rf.a2), mem[rf.a2]);
  end

  always @(posedge clk) begin
    if (rf.we3 && rf.a3 != 5'd0) mem[rf.a3] <= rf.wd3;
  end

  function automatic logic [31:0] expv(input int r, input int p);
    logic [31:0] v;
    if (r == 0) return 32'h0;
    v = SEED ^ 32'(r);
    return (p != 0) ? ~v : v;
  endfunction

  // k = cycles since the start was accepted; -1 while idle.
  int          k = -1;
  logic        model_on = 1'b0;
  logic        exp_pass = 1'b0;
  logic [4:0]  exp_faddr = 5'd0;
  logic        exp_fport = 1'b0;
  int          exp_err = 0;
  logic        pend_pass;
  logic [4:0]  pend_faddr;
  logic        pend_fport;
  int          pend_err;

  task automatic predict();
    int         cnt;
    logic       ok;
    logic [4:0] fa;
    logic       fp;
    cnt = 0; ok = 1'b1; fa = 5'd0; fp = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        logic b1;
        logic b2;
        b1 = apply_fault(i, expv(i, p)) != expv(i, p);
        b2 = apply_fault(31 - i, expv(31 - i, p)) != expv(31 - i, p);
        cnt = cnt + int'(b1) + int'(b2);
        if (cnt > 255) cnt = 255;
        if (ok && (b1 || b2)) begin
          ok = 1'b0;
          fa = b1 ? 5'(i) : 5'(31 - i);
          fp = !b1;
        end
      end
    end
    pend_pass = ok; pend_faddr = fa; pend_fport = fp; pend_err = cnt;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      k <= -1;
      model_on <= 1'b1;
      exp_pass <= 1'b0; exp_faddr <= 5'd0; exp_fport <= 1'b0; exp_err <= 0;
    end else if (k < 0) begin
      if (start) begin
        predict();
        k <= 0;
        exp_pass <= 1'b0; exp_faddr <= 5'd0; exp_fport <= 1'b0; exp_err <= 0;
      end
    end else if (k == 125) begin
      k <= 126;
      exp_pass <= pend_pass; exp_faddr <= pend_faddr;
      exp_fport <= pend_fport; exp_err <= pend_err;
    end else if (k == 126) begin
      k <= -1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin : cmp_blk
    logic        e_we;
    logic [4:0]  e_a1, e_a2, e_a3;
    logic [31:0] e_wd;
    if (model_on) begin
      e_we = 1'b0; e_a1 = 5'd0; e_a2 = 5'd0; e_a3 = 5'd0; e_wd = 32'h0;
      if (k >= 0 && k <= 30) begin
        e_we = 1'b1; e_a3 = 5'(k + 1); e_wd = expv(k + 1, 0);
      end else if (k >= 31 && k <= 62) begin
        e_a1 = 5'(k - 31); e_a2 = 5'(62 - k);
      end else if (k >= 63 && k <= 93) begin
        e_we = 1'b1; e_a3 = 5'(k - 62); e_wd = expv(k - 62, 1);
      end else if (k >= 94 && k <= 125) begin
        e_a1 = 5'(k - 94); e_a2 = 5'(125 - k);
      end
      check("busy", 32'(busy), 32'(k >= 0 && k <= 125));
      check("done", 32'(done), 32'(k == 126));
      check("we3", 32'(rf.we3), 32'(e_we));
      check("a1", 32'(rf.a1), 32'(e_a1));
      check("a2", 32'(rf.a2), 32'(e_a2));
      check("a3", 32'(rf.a3), 32'(e_a3));
      check("wd3", rf.wd3, e_wd);
      if (k < 0 || k == 126) begin
        check("pass", 32'(pass), 32'(exp_pass));
        check("fail_addr", 32'(fail_addr), 32'(exp_faddr));
        check("fail_port", 32'(fail_port), 32'(exp_fport));
`ifdef REGFILE_BIST_ERRCNT_EN
        check("err_count", 32'(err_count), 32'(exp_err));
`endif
      end
    end
  end

  logic [31:0] trace [$];
  int          lat;
  int          busy_n;

  task automatic run_test(input int width);
    int n;
    trace.delete();
    busy_n = 0;
    start = 1'b1;
    n = 0;
    for (int w = 0; w < width; w++) begin
      @(negedge clk); n++;
      if (busy) busy_n++;
      if (rf.we3 && rf.a3 == 5'd31) trace.push_back(rf.wd3);
    end
    start = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk); n++;
      if (busy) busy_n++;
      if (rf.we3 && rf.a3 == 5'd31) trace.push_back(rf.wd3);
    end
    lat = n;
    check("done_within_bound", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_wd3", rf.wd3, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    f_kind = 0;
    run_test(1);
    check("good_latency", 32'(lat), 32'd127);
    check("good_busy_cycles", 32'(busy_n), 32'd126);
    check("good_pass", 32'(pass), 32'd1);
    check("good_fail_addr", 32'(fail_addr), 32'd0);
    check("trace_count", 32'(trace.size()), 32'd2);
    if (trace.size() == 2) begin
      check("trace_p0_a31", trace[0], 32'hA5A5_001F);
      check("trace_p1_a31", trace[1], 32'h5A5A_FFE0);
    end

    f_kind = 1; f_reg = 9; f_bit = 3; f_val = 1'b0;
    run_test(1);
    check("stuck_pass", 32'(pass), 32'd0);
    check("stuck_fail_addr", 32'(fail_addr), 32'd9);
    check("stuck_fail_port", 32'(fail_port), 32'd0);
`ifdef REGFILE_BIST_ERRCNT_EN
    check("stuck_err_count", 32'(err_count), 32'd2);
`endif

    f_kind = 2;
    run_test(2);
    check("r0_pass", 32'(pass), 32'd0);
    check("r0_fail_addr", 32'(fail_addr), 32'd0);
    check("r0_fail_port", 32'(fail_port), 32'd0);

    f_kind = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(31, 62)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_we3", 32'(rf.we3), 32'd0);
    check("midrst_addrs", 32'({rf.a1, rf.a2, rf.a3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(1);
    check("midrst_rerun_pass", 32'(pass), 32'd1);

    for (int t = 0; t < 6; t++) begin
      f_kind = $urandom_range(0, 2);
      f_reg  = $urandom_range(1, 31);
      f_bit  = $urandom_range(0, 31);
      f_val  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_test($urandom_range(1, 3));
    end

    begin : held_start
      int dones;
      f_kind = 0;
      dones = 0;
      start = 1'b1;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (done) dones++;
      end
      start = 1'b0;
      check("held_start_done_pulses", 32'(dones), 32'd2);
      for (int c = 0; c < 300 && (busy || done); c++) @(negedge clk);
      check("held_start_idle", 32'(busy || done), 32'd0);
      check("held_start_pass", 32'(pass), 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
